// File: rtl/crc_serial_gen.sv
// crc_serial_gen: serial USB CRC5/CRC16 generator that streams a packet LSB-first and appends the inverted CRC MSB-first.
module crc_serial_gen #(
    parameter int CRC_W = 5,
    parameter logic [CRC_W-1:0] POLY = 5'b00101,
    parameter int MAX_PKT = 100,
    parameter int SKIP_BITS = 8,
    localparam int LEN_W = $clog2(MAX_PKT + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pkt_ready,
    input  logic [MAX_PKT-1:0] pkt_in,
    input  logic [LEN_W-1:0]   pkt_len,
    input  logic               crc_en,
    input  logic               bs_ready,
    output logic               out_bit,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);
    localparam int FC_W = $clog2(CRC_W);
    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;
    state_t state, state_nx;
    logic [MAX_PKT-1:0] shreg;
    logic [LEN_W-1:0] len, bit_cnt;
    logic use_crc;
    logic [CRC_W-1:0] crc;
    logic [FC_W-1:0] flush_cnt;
    logic accept, load, last_data, last_crc, fb;
    assign load = pkt_ready && pkt_len != '0;
    assign accept = out_valid && bs_ready;
    assign last_data = bit_cnt == len - LEN_W'(1);
    assign last_crc = flush_cnt == FC_W'(CRC_W - 1);
    assign fb = shreg[0] ^ crc[CRC_W-1];
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (load ? DATA : IDLE) :
                   state == DATA ? (accept && last_data ? (use_crc ? CRC : IDLE) : DATA) :
                   (accept && last_crc ? IDLE : CRC);
    end
    // The CRC register is shifted left while flushing, so its MSB is always the next bit out.
    always_comb begin
        out_valid = state != IDLE;
        busy = state != IDLE;
        out_bit = state == DATA ? shreg[0] : state == CRC ? ~crc[CRC_W-1] : 1'b0;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            len <= '0;
            bit_cnt <= '0;
            use_crc <= 1'b0;
            crc <= '1;
            flush_cnt <= '0;
            done <= 1'b0;
        end else begin
            done <= accept && (state == DATA ? last_data && !use_crc : state == CRC && last_crc);
            if (state == IDLE && load) begin
                shreg <= pkt_in;
                len <= pkt_len > LEN_W'(MAX_PKT) ? LEN_W'(MAX_PKT) : pkt_len;
                use_crc <= crc_en;
                crc <= '1;
                bit_cnt <= '0;
                flush_cnt <= '0;
            end else if (accept && state == DATA) begin
                shreg <= shreg >> 1;
                bit_cnt <= bit_cnt + LEN_W'(1);
                if (bit_cnt >= LEN_W'(SKIP_BITS))
                    crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end else if (accept && state == CRC) begin
                crc <= {crc[CRC_W-2:0], 1'b0};
                flush_cnt <= last_crc ? '0 : flush_cnt + FC_W'(1);
            end
        end
    end
endmodule

// File: doc/crc_serial_gen.md
Name: crc_serial_gen

Overview:
- Parametrised serial CRC generator and appender for the USB transmit path, between the protocol handler and the bit stuffer.
- Loads a parallel packet and streams it out LSB-first, skipping the PID bits for CRC purposes.
- Computes the CRC on the fly and appends the complemented CRC, MSB-first.
- One instance covers CRC5 for tokens and CRC16 for data packets. A per-packet bypass passes handshake packets through without a CRC. Output uses a proper valid/ready handshake.

Parameters:
- CRC_W, 5, CRC width (5 or 16).
- POLY, 5'b00101, generator polynomial without the x^CRC_W term (CRC16: 16'h8005).
- MAX_PKT, 100, maximum packet bits (PID + payload, excluding CRC).
- SKIP_BITS, 8, leading bits transmitted but excluded from the CRC (PID).
- LEN_W, $clog2(MAX_PKT+1), width of pkt_len (derived, not overridden).

Ports:
- clock  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- pkt_ready  input  1  protocol handler presents a packet (load strobe)
- pkt_in  input  MAX_PKT  packet bits; bit 0 is transmitted first
- pkt_len  input  LEN_W  packet length in bits, excluding CRC
- crc_en  input  1  1: append CRC; 0: bypass (no CRC)
- bs_ready  input  1  bit stuffer accepts out_bit this cycle
- out_bit  output  1  serial bit to bit stuffer
- out_valid  output  1  out_bit is valid
- busy  output  1  packet in progress; pkt_ready ignored
- done  output  1  one-cycle pulse after last bit accepted

Behaviour:
- Reset is asynchronous, active-low, reset_n; clock is clock. It takes effect mid-operation too.
- Reset values: state IDLE; out_bit 0; out_valid 0; busy 0; done 0; CRC register all ones; counters 0.
- Transfer rule: a bit is consumed only in a cycle with out_valid && bs_ready.
  - While out_valid && !bs_ready, out_bit and all state hold.
  - No dedicated pause states.
- IDLE:
  - out_valid=0, busy=0.
  - On pkt_ready with pkt_len!=0: latch pkt_in into a shift register, latch pkt_len (values > MAX_PKT are clamped to MAX_PKT) and crc_en; CRC register <= all ones; bit_cnt <= 0; go to DATA.
  - pkt_ready with pkt_len==0 is ignored.
- DATA:
  - out_valid=1, busy=1, out_bit=shreg[0].
  - On accept: shift right; bit_cnt++. If bit_cnt >= SKIP_BITS, update the CRC with this bit:
    - fb = bit ^ crc[CRC_W-1]
    - crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
  - On accepting bit pkt_len-1: go to CRC if crc_en, else go to IDLE with done=1 in the next cycle.
- CRC:
  - out_valid=1, busy=1, out_bit = ~crc[CRC_W-1-flush_cnt].
  - On accept: flush_cnt++. On accepting flush_cnt==CRC_W-1: go to IDLE, flush_cnt <= 0, done=1 for one cycle.
- Latency: first bit is valid in the cycle after the pkt_ready sample. Back-to-back transfers are 1 bit/cycle, with no bubble between DATA and CRC.
- pkt_len <= SKIP_BITS: CRC covers zero bits; appended CRC is all zeros.
- pkt_ready while busy: ignored, no effect on the stream in flight.
- pkt_ready in the same cycle as the final accept: ignored; the new packet must be presented once busy=0.
- done and pkt_ready may overlap: pkt_ready is sampled in IDLE regardless of done.
- bs_ready toggling every cycle: stream content is identical to bs_ready held high; only timing stretches.
- crc_en is sampled only at load.

Test Plan:
- CRC_W=5, OUT token: pkt_in = {11'h000, 8'hE1}, pkt_len=19, crc_en=1, bs_ready=1 -> 19 bits starting 1,0,0,0,0,1,1,1, then 0×11, then CRC 0,1,0,0,0; done pulses once; 24 valid cycles.
- CRC_W=16, POLY=16'h8005, DATA0 with empty payload: pkt_in=8'hC3, pkt_len=8 -> bits 1,1,0,0,0,0,1,1 then 16 zeros; done pulse.
- Bypass: ACK pkt_in=8'hD2, pkt_len=8, crc_en=0 -> exactly 8 bits 0,1,0,0,1,0,1,1, then IDLE and done; no CRC bits.
- Backpressure: token case with bs_ready low for 3 cycles at bit 5 and bit 21 -> identical bit sequence; out_bit stable during stalls; done delayed by 6 cycles.
- Busy and edge handling: pkt_ready pulsed mid-stream -> ignored. pkt_len=0 in IDLE -> stays IDLE, out_valid=0.
- Reset mid-CRC: assert reset_n low during CRC bit 2 -> out_valid=0 immediately; after release, a new token load produces a correct CRC 0,1,0,0,0.
